// File: rtl/counter_pkg.sv
// Shared definitions for the counter and its observer: capture FSM encoding,
// default widths and the legal-step rule.
package counter_pkg;

   localparam int CNT_W_DEF = 4;
   localparam int EVT_W_DEF = 8;

   typedef logic [1:0] cap_state_t;

   localparam cap_state_t CAP_IDLE    = 2'd0;
   localparam cap_state_t CAP_VALID   = 2'd1;
   localparam cap_state_t CAP_RELEASE = 2'd2;

   // Values arrive zero-extended to 32 bits; width selects the wrap modulus.
   function automatic logic legal_step(
      input logic [31:0] prev_cnt,
      input logic [31:0] cur_cnt,
      input logic [31:0] max_val,
      input logic        down,
      input logic        max_en,
      input int unsigned width
   );
      logic [31:0] mask;
      logic [31:0] inc_val;
      logic [31:0] dec_val;
      logic        ok;
      mask    = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
      inc_val = (prev_cnt + 32'd1) & mask;
      dec_val = (prev_cnt - 32'd1) & mask;
      if (cur_cnt == prev_cnt) begin
         ok = 1'b1;
      end else if (!down) begin
         ok = (cur_cnt == inc_val) ||
              (max_en && (prev_cnt >= max_val) && (cur_cnt == 32'd0));
      end else begin
         ok = (cur_cnt == dec_val) ||
              (max_en && (prev_cnt == 32'd0) && (cur_cnt == max_val));
      end
      return ok;
   endfunction

endpackage

// File: rtl/edge_detect.sv
// One-bit rising-edge detector; rise is high in the cycle din goes 0->1.
module edge_detect (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic rise
);

   logic din_reg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         din_reg <= 1'b0;
      end else begin
         din_reg <= din;
      end
   end

   assign rise = din & ~din_reg;

endmodule

// File: rtl/counter_observer.sv
// Passive checker beside the advanced counter: flags illegal steps, counts
// carry events and offers a req/ack snapshot of value and event count.
module counter_observer
   import counter_pkg::*;
#(
   parameter int CNT_W            = CNT_W_DEF,
   parameter int EVT_W            = EVT_W_DEF,
   parameter bit CLEAR_ON_CAPTURE = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [CNT_W-1:0] cnt_in,
   input  logic             carry_in,
   input  logic             up_down_sel,
   input  logic             max_en,
   input  logic [CNT_W-1:0] max_val,
   input  logic             clear_err,
   input  logic             capture_req,
   input  logic             capture_ack,
   output logic             step_err,
   output logic [EVT_W-1:0] carry_cnt,
   output logic [CNT_W-1:0] cap_val,
   output logic [EVT_W-1:0] cap_carry,
   output logic             cap_valid
);

   localparam logic [EVT_W-1:0] EVT_MAX = '1;

   logic [CNT_W-1:0] prev_cnt_reg;
   logic             prev_valid_reg;
   logic             prev_dir_reg;
   logic             prev_max_en_reg;
   logic [CNT_W-1:0] prev_max_val_reg;
   logic             step_err_reg;
   logic [EVT_W-1:0] carry_cnt_reg;
   logic [CNT_W-1:0] cap_val_reg;
   logic [EVT_W-1:0] cap_carry_reg;
   logic             cap_valid_reg;
   cap_state_t       state_reg;
   cap_state_t       state_next;

   logic cfg_same;
   logic step_bad;
   logic carry_rise;
   logic capture_take;

   edge_detect u_carry_edge (
      .clk   (clk),
      .reset (reset),
      .din   (carry_in),
      .rise  (carry_rise)
   );

   // A configuration change makes the previous sample incomparable, so skip it.
   assign cfg_same = (prev_dir_reg == up_down_sel) &&
                     (prev_max_en_reg == max_en) &&
                     (prev_max_val_reg == max_val);

   assign step_bad = prev_valid_reg && cfg_same &&
                     !legal_step(32'(prev_cnt_reg), 32'(cnt_in), 32'(max_val),
                                 up_down_sel, max_en, CNT_W);

   assign capture_take = (state_reg == CAP_IDLE) && capture_req;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prev_cnt_reg     <= '0;
         prev_valid_reg   <= 1'b0;
         prev_dir_reg     <= 1'b0;
         prev_max_en_reg  <= 1'b0;
         prev_max_val_reg <= '0;
         step_err_reg     <= 1'b0;
      end else begin
         prev_cnt_reg     <= cnt_in;
         prev_valid_reg   <= 1'b1;
         prev_dir_reg     <= up_down_sel;
         prev_max_en_reg  <= max_en;
         prev_max_val_reg <= max_val;
         if (step_bad) begin
            step_err_reg <= 1'b1;
         end else if (clear_err) begin
            step_err_reg <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         carry_cnt_reg <= '0;
      end else if (CLEAR_ON_CAPTURE && capture_take) begin
         carry_cnt_reg <= carry_rise ? EVT_W'(1) : '0;
      end else if (carry_rise && (carry_cnt_reg != EVT_MAX)) begin
         carry_cnt_reg <= carry_cnt_reg + EVT_W'(1);
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         CAP_IDLE:    if (capture_req)  state_next = CAP_VALID;
         CAP_VALID:   if (capture_ack)  state_next = CAP_RELEASE;
         CAP_RELEASE: if (!capture_req) state_next = CAP_IDLE;
         default:                       state_next = CAP_IDLE;
      endcase
   end

   // The snapshot takes carry_cnt as it stood before this edge's update.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg     <= CAP_IDLE;
         cap_val_reg   <= '0;
         cap_carry_reg <= '0;
         cap_valid_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (capture_take) begin
            cap_val_reg   <= cnt_in;
            cap_carry_reg <= carry_cnt_reg;
            cap_valid_reg <= 1'b1;
         end else if ((state_reg == CAP_VALID) && capture_ack) begin
            cap_valid_reg <= 1'b0;
         end
      end
   end

   assign step_err  = step_err_reg;
   assign carry_cnt = carry_cnt_reg;
   assign cap_val   = cap_val_reg;
   assign cap_carry = cap_carry_reg;
   assign cap_valid = cap_valid_reg;

endmodule

// File: tb/tb_counter_observer.sv
// Directed bench for counter_observer: step-check vector table plus
// hand-written carry, capture and reset sequences.
module tb_counter_observer;

   logic       clk;
   logic       reset;
   logic [3:0] cnt_in;
   logic       carry_in;
   logic       up_down_sel;
   logic       max_en;
   logic [3:0] max_val;
   logic       clear_err;
   logic       capture_req;
   logic       capture_ack;
   logic       step_err;
   logic [7:0] carry_cnt;
   logic [3:0] cap_val;
   logic [7:0] cap_carry;
   logic       cap_valid;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0] cnt;
      logic       dir;
      logic       men;
      logic [3:0] mv;
      logic       clr;
      logic       exp_err;
   } vec_t;

   vec_t vecs[$];

   counter_observer #(
      .CNT_W            (4),
      .EVT_W            (8),
      .CLEAR_ON_CAPTURE (1'b0)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .cnt_in      (cnt_in),
      .carry_in    (carry_in),
      .up_down_sel (up_down_sel),
      .max_en      (max_en),
      .max_val     (max_val),
      .clear_err   (clear_err),
      .capture_req (capture_req),
      .capture_ack (capture_ack),
      .step_err    (step_err),
      .carry_cnt   (carry_cnt),
      .cap_val     (cap_val),
      .cap_carry   (cap_carry),
      .cap_valid   (cap_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic add(input logic [3:0] c, input logic d, input logic me,
                      input logic [3:0] mv, input logic cl, input logic e);
      vec_t v;
      v.cnt = c; v.dir = d; v.men = me; v.mv = mv; v.clr = cl; v.exp_err = e;
      vecs.push_back(v);
   endtask

   task automatic carry_pulse();
      carry_in = 1'b1;
      step();
      carry_in = 1'b0;
      step();
   endtask

   initial begin
      reset = 1'b0; cnt_in = '0; carry_in = 1'b0; up_down_sel = 1'b0;
      max_en = 1'b0; max_val = '0; clear_err = 1'b0;
      capture_req = 1'b0; capture_ack = 1'b0;
      #3;
      chk("reset_step_err", 32'(step_err), 0);
      chk("reset_carry_cnt", 32'(carry_cnt), 0);
      chk("reset_cap_valid", 32'(cap_valid), 0);
      chk("reset_cap_val", 32'(cap_val), 0);
      chk("reset_cap_carry", 32'(cap_carry), 0);
      @(negedge clk);
      reset = 1'b1;

      // Free-running up count with full wrap, one step every 3 cycles.
      for (int i = 0; i <= 16; i++) begin
         cnt_in = 4'(i);
         if (i == 15) chk("carry_before_wrap", 32'(carry_cnt), 0);
         for (int k = 0; k < 3; k++) begin
            carry_in = (i == 16 && k == 0);
            step();
            chk("upcount_no_err", 32'(step_err), 0);
         end
      end
      carry_in = 1'b0;
      chk("carry_after_wrap", 32'(carry_cnt), 1);
      $display("up count 0..15..0 done step_err=%0d carry_cnt=%0d", step_err, carry_cnt);

      // Step-check table, max_val=8.
      add(4'd0, 0, 1, 4'd8, 0, 0);
      for (int i = 1; i <= 8; i++) add(4'(i), 0, 1, 4'd8, 0, 0);
      add(4'd0, 0, 1, 4'd8, 0, 0);
      add(4'd1, 0, 1, 4'd8, 0, 0);
      add(4'd2, 0, 1, 4'd8, 0, 0);
      add(4'd3, 0, 1, 4'd8, 0, 0);
      add(4'd5, 0, 1, 4'd8, 0, 1);
      add(4'd5, 0, 1, 4'd8, 1, 0);
      add(4'd6, 0, 1, 4'd8, 0, 0);
      add(4'd9, 0, 1, 4'd8, 1, 1);
      add(4'd9, 0, 1, 4'd8, 1, 0);
      add(4'd0, 1, 1, 4'd8, 0, 0);
      add(4'd8, 1, 1, 4'd8, 0, 0);
      add(4'd7, 1, 1, 4'd8, 0, 0);
      add(4'd6, 1, 1, 4'd8, 0, 0);
      add(4'd5, 1, 1, 4'd8, 0, 0);
      add(4'd4, 1, 1, 4'd8, 0, 0);
      add(4'd2, 1, 1, 4'd8, 0, 1);
      add(4'd2, 1, 1, 4'd8, 1, 0);
      add(4'd10, 0, 1, 4'd8, 0, 0);
      add(4'd11, 0, 1, 4'd8, 0, 0);
      add(4'd0, 0, 1, 4'd8, 0, 0);
      for (int i = 0; i < vecs.size(); i++) begin
         cnt_in = vecs[i].cnt; up_down_sel = vecs[i].dir; max_en = vecs[i].men;
         max_val = vecs[i].mv; clear_err = vecs[i].clr;
         step();
         $display("vec %0d cnt=%0d dir=%0d clr=%0d step_err=%0d exp=%0d",
                  i, vecs[i].cnt, vecs[i].dir, vecs[i].clr, step_err, vecs[i].exp_err);
         chk($sformatf("vec%0d_step_err", i), 32'(step_err), 32'(vecs[i].exp_err));
      end
      clear_err = 1'b0;

      // Bring carry count from 1 to 4 before capturing.
      for (int i = 0; i < 3; i++) carry_pulse();
      chk("carry_cnt_4", 32'(carry_cnt), 4);

      cnt_in = 4'd6; capture_req = 1'b1;
      step();
      chk("cap1_valid", 32'(cap_valid), 1);
      chk("cap1_val", 32'(cap_val), 6);
      chk("cap1_carry", 32'(cap_carry), 4);
      cnt_in = 4'd7;
      for (int k = 0; k < 5; k++) begin
         carry_in = (k == 0);
         step();
         chk("hold_valid", 32'(cap_valid), 1);
         chk("hold_val", 32'(cap_val), 6);
         chk("hold_carry", 32'(cap_carry), 4);
      end
      carry_in = 1'b0;
      chk("carry_cnt_5", 32'(carry_cnt), 5);
      $display("capture 1 held cap_val=%0d cap_carry=%0d", cap_val, cap_carry);
      capture_ack = 1'b1;
      step();
      chk("ack_clears_valid", 32'(cap_valid), 0);
      for (int k = 0; k < 2; k++) begin
         step();
         chk("release_no_recapture", 32'(cap_valid), 0);
      end
      capture_ack = 1'b0; capture_req = 1'b0;
      step();
      chk("idle_no_capture", 32'(cap_valid), 0);
      cnt_in = 4'd9; capture_req = 1'b1; carry_in = 1'b1;
      step();
      carry_in = 1'b0;
      chk("cap2_valid", 32'(cap_valid), 1);
      chk("cap2_val", 32'(cap_val), 9);
      chk("cap2_carry_pre_inc", 32'(cap_carry), 5);
      chk("cap2_carry_cnt", 32'(carry_cnt), 6);
      $display("capture 2 cap_val=%0d cap_carry=%0d carry_cnt=%0d", cap_val, cap_carry, carry_cnt);

      // Asynchronous reset while a capture is pending.
      reset = 1'b0;
      #2;
      chk("async_cap_valid", 32'(cap_valid), 0);
      chk("async_cap_val", 32'(cap_val), 0);
      chk("async_cap_carry", 32'(cap_carry), 0);
      chk("async_carry_cnt", 32'(carry_cnt), 0);
      chk("async_step_err", 32'(step_err), 0);
      capture_req = 1'b0; cnt_in = 4'd11; up_down_sel = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      step();
      chk("first_sample_no_err", 32'(step_err), 0);
      cnt_in = 4'd12;
      step();
      chk("post_reset_legal", 32'(step_err), 0);
      cnt_in = 4'd14;
      step();
      chk("post_reset_illegal", 32'(step_err), 1);
      $display("reset recovery step_err=%0d", step_err);

      // Saturation of the carry event counter.
      for (int i = 0; i < 255; i++) carry_pulse();
      chk("carry_at_255", 32'(carry_cnt), 255);
      for (int i = 0; i < 45; i++) carry_pulse();
      chk("carry_saturated", 32'(carry_cnt), 255);
      $display("300 carry pulses carry_cnt=%0d", carry_cnt);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
